// File: rtl/banner_scroll_ctrl.sv
// Banner scroll controller: programmable-rate step prescaler, idle/run/pause FSM
// and a position tracker with modulo wrap or ping-pong (bounce) reversal.
module banner_scroll_ctrl #(
   parameter int unsigned BASE_DIV = 6_250_000,
   parameter int unsigned MSG_LEN  = 10,
   parameter int unsigned POS_W    = 4,
   parameter int unsigned CNT_W    = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_stop,
   input  logic             clear,
   input  logic             dir_toggle,
   input  logic             faster,
   input  logic             slower,
   input  logic             bounce,
   output logic             enable,
   output logic             dir,
   output logic             running,
   output logic [1:0]       speed,
   output logic [POS_W-1:0] pos
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   localparam logic [POS_W-1:0] LAST = POS_W'(MSG_LEN - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, period_m1;
   logic             en_q, en_d;
   logic             dir_q, dir_d;
   logic             run_q, run_d;
   logic [1:0]       speed_q, speed_d;
   logic [POS_W-1:0] pos_q, pos_d, pos_step;
   logic             flip;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         dir_q   <= 1'b0;
         run_q   <= 1'b0;
         speed_q <= '0;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         dir_q   <= dir_d;
         run_q   <= run_d;
         speed_q <= speed_d;
         pos_q   <= pos_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      en_d      = 1'b0;
      speed_d   = speed_q;
      pos_d     = pos_q;
      pos_step  = pos_q;
      flip      = 1'b0;
      period_m1 = (CNT_W'(BASE_DIV) << speed_q) - CNT_W'(1);

      // >= rather than == so a speed decrease that strands the count above
      // the new terminal value still fires on the next edge.
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start_stop) state_d = RUN;
         end
         RUN: begin
            if (cnt_q >= period_m1) begin
               cnt_d = '0;
               en_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (start_stop) state_d = PAUSE;
         end
         PAUSE: begin
            if (start_stop) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase

      // The step always wraps modulo MSG_LEN; in bounce mode the flip keeps
      // the walk inside the path, and an out-of-path start just wraps once.
      if (en_q) begin
         if (!dir_q) pos_step = (pos_q == LAST) ? '0 : pos_q + POS_W'(1);
         else        pos_step = (pos_q == '0) ? LAST : pos_q - POS_W'(1);
         pos_d = pos_step;
         flip  = bounce && (dir_q ? (pos_step == '0) : (pos_step == LAST));
      end
      dir_d = dir_q ^ dir_toggle ^ flip;

      if (faster && !slower && speed_q != 2'd0)
         speed_d = speed_q - 2'd1;
      else if (slower && !faster && speed_q != 2'd3)
         speed_d = speed_q + 2'd1;

      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         en_d    = 1'b0;
         pos_d   = '0;
         dir_d   = 1'b0;
      end
      run_d = (state_d == RUN);
   end

   assign enable  = en_q;
   assign dir     = dir_q;
   assign running = run_q;
   assign speed   = speed_q;
   assign pos     = pos_q;

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Bench for banner_scroll_ctrl: directed scenarios plus random pulses, all
// checked every cycle against an integer-arithmetic reference model.
module tb_banner_scroll_ctrl;

   localparam int BASE_DIV = 4;
   localparam int MSG_LEN  = 4;
   localparam int POS_W    = 3;
   localparam int CNT_W    = 6;

   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] SS   = 5'b10000;
   localparam logic [4:0] CL   = 5'b01000;
   localparam logic [4:0] DT   = 5'b00100;
   localparam logic [4:0] FA   = 5'b00010;
   localparam logic [4:0] SL   = 5'b00001;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_stop = 1'b0, clear = 1'b0, dir_toggle = 1'b0;
   logic             faster = 1'b0, slower = 1'b0, bounce = 1'b0;
   logic             enable, dir, running;
   logic [1:0]       speed;
   logic [POS_W-1:0] pos;

   int vectors = 0;
   int miscompares = 0;
   int cyc_no = 0;

   // Reference model: state 0=idle, 1=run, 2=pause.
   int m_state, m_cnt, m_speed, m_pos, m_dir, m_en;

   always #5 clk = ~clk;

   banner_scroll_ctrl #(
      .BASE_DIV(BASE_DIV),
      .MSG_LEN (MSG_LEN),
      .POS_W   (POS_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (rst_n),
      .start_stop(start_stop),
      .clear     (clear),
      .dir_toggle(dir_toggle),
      .faster    (faster),
      .slower    (slower),
      .bounce    (bounce),
      .enable    (enable),
      .dir       (dir),
      .running   (running),
      .speed     (speed),
      .pos       (pos)
   );

   function automatic logic [7:0] model_vec();
      logic [7:0] v;
      v = {m_en[0], m_dir[0], (m_state == 1), m_speed[1:0], m_pos[2:0]};
      return v;
   endfunction

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_speed = 0; m_pos = 0; m_dir = 0; m_en = 0;
   endtask

   task automatic model_step();
      int period  = BASE_DIV * (1 << m_speed);
      int n_state = m_state;
      int n_cnt   = m_cnt;
      int n_speed = m_speed;
      int n_pos   = m_pos;
      int n_dir;
      int n_en    = 0;
      int flip    = 0;
      if (m_state == 0) n_cnt = 0;
      else if (m_state == 1) begin
         if (m_cnt >= period - 1) begin n_cnt = 0; n_en = 1; end
         else n_cnt = m_cnt + 1;
      end
      if (m_en == 1) begin
         n_pos = (m_dir == 0) ? (m_pos + 1) % MSG_LEN : (m_pos + MSG_LEN - 1) % MSG_LEN;
         if (bounce && n_pos == ((m_dir == 0) ? MSG_LEN - 1 : 0)) flip = 1;
      end
      n_dir = m_dir ^ int'(dir_toggle) ^ flip;
      if (start_stop) n_state = (m_state == 1) ? 2 : 1;
      if (faster && !slower) n_speed = (m_speed > 0) ? m_speed - 1 : 0;
      else if (slower && !faster) n_speed = (m_speed < 3) ? m_speed + 1 : 3;
      if (clear) begin
         n_state = 0; n_cnt = 0; n_pos = 0; n_dir = 0; n_en = 0;
      end
      m_state = n_state; m_cnt = n_cnt; m_speed = n_speed;
      m_pos = n_pos; m_dir = n_dir; m_en = n_en;
   endtask

   task automatic tick(input logic [4:0] p);
      {start_stop, clear, dir_toggle, faster, slower} = p;
      @(posedge clk);
      model_step();
      #1;
      {start_stop, clear, dir_toggle, faster, slower} = '0;
      cyc_no++;
   endtask

   task automatic test_reset();
      model_reset();
      vectors++;
      if ({enable, dir, running, speed, pos} !== model_vec()) begin
         miscompares++;
         $display("FAIL reset_state: dut=%b exp=%b", {enable, dir, running, speed, pos}, model_vec());
      end
      rst_n = 1'b1;
      tick(NONE);
      vectors++;
      if ({enable, dir, running, speed, pos} !== model_vec()) begin
         miscompares++;
         $display("FAIL reset_idle: dut=%b exp=%b", {enable, dir, running, speed, pos}, model_vec());
      end
   endtask

   task automatic test_run_wrap();
      int seen[$];
      int en_at[$];
      int exp_seq[5] = '{1, 2, 3, 0, 1};
      int c0;
      logic [POS_W-1:0] last_pos;
      bounce = 1'b0;
      tick(SS);
      c0 = cyc_no;
      vectors++;
      if (running !== 1'b1) begin
         miscompares++;
         $display("FAIL run_running: got %b want 1", running);
      end
      last_pos = pos;
      for (int i = 0; i < 100 && seen.size() < 5; i++) begin
         tick(NONE);
         vectors++;
         if ({enable, dir, running, speed, pos} !== model_vec()) begin
            miscompares++;
            $display("FAIL run_model cyc=%0d: dut=%b exp=%b", cyc_no, {enable, dir, running, speed, pos}, model_vec());
         end
         if (enable === 1'b1) en_at.push_back(cyc_no);
         if (pos !== last_pos) begin seen.push_back(int'(pos)); last_pos = pos; end
      end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (i >= seen.size() || seen[i] != exp_seq[i]) begin
            miscompares++;
            $display("FAIL run_pos_seq[%0d]: got %0d want %0d", i, (i < seen.size()) ? seen[i] : -1, exp_seq[i]);
         end
      end
      vectors++;
      if (en_at.size() == 0 || en_at[0] - c0 != BASE_DIV) begin
         miscompares++;
         $display("FAIL run_first_latency: got %0d want %0d", (en_at.size() > 0) ? en_at[0] - c0 : -1, BASE_DIV);
      end
      for (int i = 1; i < en_at.size(); i++) begin
         vectors++;
         if (en_at[i] - en_at[i-1] != BASE_DIV) begin
            miscompares++;
            $display("FAIL run_period: got %0d want %0d", en_at[i] - en_at[i-1], BASE_DIV);
         end
      end
   endtask

   task automatic test_speed();
      int en_at[$];
      tick(CL);
      for (int i = 0; i < 5; i++) begin
         tick(SL);
         vectors++;
         if (speed !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
            miscompares++;
            $display("FAIL speed_slower[%0d]: got %0d want %0d", i, speed, (i + 1 > 3) ? 3 : i + 1);
         end
      end
      tick(SS);
      for (int i = 0; i < 200 && en_at.size() < 2; i++) begin
         tick(NONE);
         vectors++;
         if ({enable, dir, running, speed, pos} !== model_vec()) begin
            miscompares++;
            $display("FAIL speed_model cyc=%0d: dut=%b exp=%b", cyc_no, {enable, dir, running, speed, pos}, model_vec());
         end
         if (enable === 1'b1) en_at.push_back(cyc_no);
      end
      vectors++;
      if (en_at.size() < 2 || en_at[1] - en_at[0] != BASE_DIV * 8) begin
         miscompares++;
         $display("FAIL speed_period32: got %0d want %0d", (en_at.size() >= 2) ? en_at[1] - en_at[0] : -1, BASE_DIV * 8);
      end
      for (int i = 0; i < 5; i++) begin
         tick(FA);
         vectors++;
         if ({enable, dir, running, speed, pos} !== model_vec() || speed !== 2'((2 - i < 0) ? 0 : 2 - i)) begin
            miscompares++;
            $display("FAIL speed_faster[%0d]: got %0d want %0d", i, speed, (2 - i < 0) ? 0 : 2 - i);
         end
      end
      tick(FA | SL);
      vectors++;
      if (speed !== 2'd0) begin
         miscompares++;
         $display("FAIL speed_both_at0: got %0d want 0", speed);
      end
      tick(SL);
      tick(FA | SL);
      vectors++;
      if (speed !== 2'd1) begin
         miscompares++;
         $display("FAIL speed_both_at1: got %0d want 1", speed);
      end
      tick(FA);
   endtask

   task automatic test_bounce();
      int seen_p[$];
      int seen_d[$];
      int exp_p[7] = '{1, 2, 3, 2, 1, 0, 1};
      int exp_d[7] = '{0, 0, 1, 1, 1, 0, 0};
      logic [POS_W-1:0] last_pos;
      logic prev_dir;
      tick(CL);
      bounce = 1'b1;
      tick(SS);
      last_pos = pos;
      prev_dir = dir;
      for (int i = 0; i < 200 && seen_p.size() < 7; i++) begin
         tick(NONE);
         vectors++;
         if ({enable, dir, running, speed, pos} !== model_vec()) begin
            miscompares++;
            $display("FAIL bounce_model cyc=%0d: dut=%b exp=%b", cyc_no, {enable, dir, running, speed, pos}, model_vec());
         end
         if (enable === 1'b1) begin
            vectors++;
            if (dir !== prev_dir) begin
               miscompares++;
               $display("FAIL bounce_dir_stable: got %b want %b", dir, prev_dir);
            end
         end
         if (pos !== last_pos) begin
            seen_p.push_back(int'(pos)); seen_d.push_back(int'(dir)); last_pos = pos;
         end
         prev_dir = dir;
      end
      for (int i = 0; i < 7; i++) begin
         vectors++;
         if (i >= seen_p.size() || seen_p[i] != exp_p[i] || seen_d[i] != exp_d[i]) begin
            miscompares++;
            $display("FAIL bounce_seq[%0d]: got pos=%0d dir=%0d want pos=%0d dir=%0d", i,
                     (i < seen_p.size()) ? seen_p[i] : -1, (i < seen_d.size()) ? seen_d[i] : -1, exp_p[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_pause();
      int n;
      bit found;
      tick(CL);
      bounce = 1'b0;
      tick(SS);
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (m_state == 1 && m_cnt == 1) found = 1;
         else tick(NONE);
      end
      tick(SS);
      vectors++;
      if (!found || running !== 1'b0) begin
         miscompares++;
         $display("FAIL pause_enter: found=%0d running=%b want running=0", found, running);
      end
      for (int i = 0; i < 20; i++) begin
         tick(NONE);
         vectors++;
         if (enable !== 1'b0 || {enable, dir, running, speed, pos} !== model_vec()) begin
            miscompares++;
            $display("FAIL pause_hold cyc=%0d: dut=%b exp=%b", cyc_no, {enable, dir, running, speed, pos}, model_vec());
         end
      end
      tick(SS);
      n = 0;
      for (int i = 0; i < 50 && enable !== 1'b1; i++) begin
         tick(NONE);
         n++;
      end
      vectors++;
      if (enable !== 1'b1 || n != 2) begin
         miscompares++;
         $display("FAIL pause_resume_latency: got %0d want 2", n);
      end
   endtask

   task automatic test_dir_toggle();
      bit found;
      logic d0;
      tick(CL);
      bounce = 1'b1;
      tick(SS);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (enable === 1'b1 && m_pos == MSG_LEN - 2 && m_dir == 0) found = 1;
         else tick(NONE);
      end
      d0 = dir;
      tick(DT);
      vectors++;
      if (!found || dir !== d0 || pos !== 3'(MSG_LEN - 1)) begin
         miscompares++;
         $display("FAIL toggle_vs_flip: found=%0d got dir=%b pos=%0d want dir=%b pos=%0d", found, dir, pos, d0, MSG_LEN - 1);
      end
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (enable === 1'b1 && m_pos == MSG_LEN - 1 && m_dir == 1) found = 1;
         else tick(NONE);
      end
      tick(DT);
      vectors++;
      if (!found || pos !== 3'(MSG_LEN - 2) || dir !== 1'b0) begin
         miscompares++;
         $display("FAIL toggle_in_step: found=%0d got pos=%0d dir=%b want pos=%0d dir=0", found, pos, dir, MSG_LEN - 2);
      end
      vectors++;
      if ({enable, dir, running, speed, pos} !== model_vec()) begin
         miscompares++;
         $display("FAIL toggle_model: dut=%b exp=%b", {enable, dir, running, speed, pos}, model_vec());
      end
   endtask

   task automatic test_clear();
      bit found;
      tick(CL);
      bounce = 1'b0;
      tick(SS);
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (enable === 1'b1 && pos === 3'd2) found = 1;
         else tick(NONE);
      end
      tick(CL);
      vectors++;
      if (!found || pos !== '0 || dir !== 1'b0 || running !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_in_step: found=%0d got pos=%0d dir=%b running=%b want 0 0 0", found, pos, dir, running);
      end
      for (int i = 0; i < 20; i++) begin
         tick(NONE);
         vectors++;
         if (enable !== 1'b0 || {enable, dir, running, speed, pos} !== model_vec()) begin
            miscompares++;
            $display("FAIL clear_idle cyc=%0d: dut=%b exp=%b", cyc_no, {enable, dir, running, speed, pos}, model_vec());
         end
      end
   endtask

   task automatic test_async_reset();
      bit found;
      tick(SL);
      tick(SS);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (enable === 1'b1 && pos !== '0) found = 1;
         else tick(NONE);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (!found || {enable, dir, running, speed, pos} !== 8'b0) begin
         miscompares++;
         $display("FAIL async_reset: found=%0d dut=%b want 00000000", found, {enable, dir, running, speed, pos});
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [4:0] p;
      for (int i = 0; i < 1500; i++) begin
         p = '0;
         if ($urandom_range(0, 11) == 0) p[4] = 1'b1;
         if ($urandom_range(0, 79) == 0) p[3] = 1'b1;
         if ($urandom_range(0, 9) == 0)  p[2] = 1'b1;
         if ($urandom_range(0, 15) == 0) p[1] = 1'b1;
         if ($urandom_range(0, 15) == 0) p[0] = 1'b1;
         if ($urandom_range(0, 39) == 0) bounce = ~bounce;
         tick(p);
         vectors++;
         if ({enable, dir, running, speed, pos} !== model_vec()) begin
            miscompares++;
            $display("FAIL random cyc=%0d: dut=%b exp=%b", cyc_no, {enable, dir, running, speed, pos}, model_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_run_wrap();
      test_speed();
      test_bounce();
      test_pause();
      test_dir_toggle();
      test_clear();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
